delay_sum_reader: RTL and testbench
===================================

# delay_sum_reader

Consumer of the per-microphone delay indices produced by the beamforming delta generator. It buffers the TDM sample stream from the 4×4 microphone array in a circular history RAM. For each completed frame it reads one delay-compensated sample per channel and accumulates them into a single delay-and-sum output word. It sits between the ADC/I2S deserializer and the audio output path.

## Interface
- DMIN, 147: smallest legal delta; maps to the largest age.
- DMAX, 167: largest legal delta; maps to age 0.
- FRAMES_LOG2, 8: history depth is 2^FRAMES_LOG2 frames.
- SW, 16: sample width, signed.
- i_clk  in  1  sole clock. Every input and output is synchronous to it.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  one sample word is present this cycle.
- i_first  in  1  qualifies i_valid; the word is channel 0 of a new frame.
- i_sample  in  SW signed  sample word. Channels arrive in order 0..15.
- i_delta  in  [7:0] ×16 (unpacked [15:0])  per-channel delta from the delta generator.
- o_valid  out  1  one-cycle pulse; o_sum is valid.
- o_sum  out  SW+4 signed  delay-and-sum result. Held until the next o_valid.
- o_overrun  out  1  sticky; a frame was skipped because the block was busy.
- o_sync_err  out  1  sticky; i_first arrived with a partial frame in progress.

## Operation
- Write side:
  - The channel counter ch (4 bits) advances on each i_valid.
  - The word is written to RAM address {wframe, ch}.
  - When the channel-15 word is accepted, the frame is complete: wframe increments (mod 2^FRAMES_LOG2) and the warm-up counter increments, saturating at DMAX-DMIN+1 = 21.
- Resync: if i_valid && i_first && ch≠0:
  - The partial frame is discarded: wframe is not advanced, and writing restarts at ch=0 of the same wframe.
  - o_sync_err is set.
  - If i_first is low at ch=0, the word is still accepted as channel 0.
- Trigger: on frame completion with warm-up ≥21, the completed frame index F is queued for summing. If warm-up <21, nothing is queued and there is no o_valid.
- Age: age_m = DMAX − clamp(i_delta[m], DMIN, DMAX), giving a range of 0..20. The read address for channel m is {F − age_m mod 2^FRAMES_LOG2, m}.
- i_delta is sampled channel-by-channel at the time of each read issue. The delta generator holds i_delta stable while a focal point is in use.
- Sum: the accumulator is SW+4 bits signed and reset to 0 at the start of each job. Each read word is sign-extended and added. The sum cannot overflow.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE → READ when a job is queued.
  - READ issues reads for ch 0..15, one per cycle.
  - READ → DRAIN after ch15 is issued. DRAIN adds the last returned word.
  - DRAIN → DONE. In DONE, o_sum is registered and o_valid is pulsed.
  - DONE → READ if a pending job exists, otherwise DONE → IDLE.
- Queue: one pending slot holding F.
  - A completion while the FSM is not IDLE fills the slot.
  - A completion while the slot is already full sets o_overrun. That frame is written to RAM but not summed.
  - A completion in the same cycle as DONE fills the slot, and the slot is consumed on the next cycle.
- Writes proceed in every state. Summing reads only completed frames, so the write pointer and the read addresses never collide.

## Timing
- Reset values:
  - o_valid=0, o_sum=0, o_overrun=0, o_sync_err=0.
  - ch=0, wframe=0, warm-up=0, FSM=IDLE, pending slot empty.
  - RAM contents are not cleared. Warm-up guarantees they are never summed.
- Latency: the channel-15 word of frame F is accepted at edge 0.
  - Reads are issued in cycles 1..16.
  - RAM read latency is 1 cycle.
  - o_valid is high in cycle 18.
  - Busy window is cycles 1..18.
- Frame spacing: minimum sustainable spacing is 18 cycles. Back-to-back frames (16-cycle spacing) eventually assert o_overrun.
- Reset mid-operation: reset in any state aborts the job with no o_valid, and warm-up restarts from 0.

## Structure
- Package beamform_pkg holds:
  - NUM_MIC=16, SW, DMIN, DMAX, FRAMES_LOG2.
  - The FSM state enum.
  - A function that clamps a delta and converts it to an age.
- Sub-module sample_history_ram: simple dual-port RAM, 1 write port and 1 read port, registered read. Width SW, depth 16·2^FRAMES_LOG2.
- Top level contains the write counters, warm-up counter, pending slot, FSM and accumulator.

## Test plan
- Warm-up with aligned channels:
  - Stimulus: all i_delta=167; channel m always sends m+1; frames spaced 40 cycles.
  - Required: frames 0..19 produce no o_valid.
  - Required: frame 20 onward gives o_sum=136, with o_valid 18 cycles after the ch15 word.
- Maximum age on one channel:
  - Stimulus: i_delta[0]=147, others 167. Channel 0 sends value = frame index f; other channels send 0.
  - Required: the sum after frame 30 is 10.
  - Required: after frame 260, o_sum=240 (frame index 240 stored in RAM with 8-bit wrap, 256-frame history).
- Clamping: i_delta[0]=200 and i_delta[1]=100 behave exactly like 167 and 147.
- Overrun:
  - Stimulus: contiguous i_valid for 40 frames after warm-up.
  - Required: o_overrun rises.
  - Required: every o_valid still carries a correct sum for the frame it was issued for.
- Resync: i_first at ch=7 → o_sync_err=1, wframe is unchanged, and the next 16 words form one frame.
- Signed extremes and reset:
  - Stimulus: all 16 channels send −32768.
  - Required: o_sum = −524288.
  - Stimulus: i_rst during READ.
  - Required: no o_valid, and the next 20 frames are silent.

Source files
------------

// File: rtl/beamform_pkg.sv
// beamform_pkg: shared constants, FSM state type and delta-to-age conversion for the delay-and-sum reader.
package beamform_pkg;
    localparam int NUM_MIC     = 16;
    localparam int SW          = 16;
    localparam int DMIN        = 147;
    localparam int DMAX        = 167;
    localparam int FRAMES_LOG2 = 8;
    localparam int WARM_MAX    = DMAX - DMIN + 1;
    localparam int AW          = 4 + FRAMES_LOG2;
    localparam int OW          = SW + 4;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    function automatic logic [4:0] delta_to_age(input logic [7:0] delta);
        int d;
        d = int'(delta);
        d = d < DMIN ? DMIN : d > DMAX ? DMAX : d;
        return 5'(DMAX - d);
    endfunction
endpackage

// File: rtl/sample_history_ram.sv
// sample_history_ram: simple dual-port sample history, one write port and one registered read port.
module sample_history_ram
    import beamform_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic signed [SW-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic signed [SW-1:0] rdata
);
    logic signed [SW-1:0] mem [0:(1 << AW) - 1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/delay_sum_reader.sv
// delay_sum_reader: buffers the TDM microphone stream and emits one delay-and-sum word per completed frame.
module delay_sum_reader
    import beamform_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic                 i_first,
    input  logic signed [SW-1:0] i_sample,
    input  logic [7:0]           i_delta [NUM_MIC-1:0],
    output logic                 o_valid,
    output logic signed [OW-1:0] o_sum,
    output logic                 o_overrun,
    output logic                 o_sync_err
);
    logic [3:0] ch, wch, rch;
    logic [FRAMES_LOG2-1:0] wframe, rframe, pend_frame, age;
    logic [4:0] warm;
    logic pending, resync, complete, trigger, start, consume, fill;
    state_t state, state_next;
    logic signed [OW-1:0] acc, ext;
    logic [AW-1:0] waddr, raddr;
    logic signed [SW-1:0] rdata;

    assign resync   = i_valid && i_first && ch != 4'd0;
    assign wch      = resync ? 4'd0 : ch;
    assign complete = i_valid && !resync && ch == 4'd15;
    assign trigger  = complete && warm >= 5'(WARM_MAX - 1);
    assign waddr    = {wframe, wch};
    assign age      = FRAMES_LOG2'(delta_to_age(i_delta[rch]));
    assign raddr    = {rframe - age, rch};
    assign ext      = {{(OW - SW){rdata[SW-1]}}, rdata};

    // A job starts straight from a completion only when idle with nothing pending;
    // every other triggering completion goes through the single pending slot.
    assign consume = start && pending;
    assign fill    = trigger && !(start && !pending);

    always_comb begin
        start      = (state == IDLE && (pending || trigger)) || (state == DONE && pending);
        state_next = start ? READ :
                     state == READ ? (rch == 4'd15 ? DRAIN : READ) :
                     state == DRAIN ? DONE : IDLE;
    end

    sample_history_ram u_ram (
        .clk   (i_clk),
        .we    (i_valid),
        .waddr (waddr),
        .wdata (i_sample),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ch         <= 4'd0;
            wframe     <= '0;
            warm       <= 5'd0;
            state      <= IDLE;
            pending    <= 1'b0;
            pend_frame <= '0;
            rframe     <= '0;
            rch        <= 4'd0;
            acc        <= '0;
            o_valid    <= 1'b0;
            o_sum      <= '0;
            o_overrun  <= 1'b0;
            o_sync_err <= 1'b0;
        end else begin
            state   <= state_next;
            o_valid <= state == DRAIN;
            if (i_valid) ch <= wch + 4'd1;
            if (resync) o_sync_err <= 1'b1;
            if (complete) begin
                wframe <= wframe + FRAMES_LOG2'(1);
                warm   <= warm == 5'(WARM_MAX) ? warm : warm + 5'd1;
            end
            if (fill && pending && !consume) o_overrun <= 1'b1;
            else if (fill) begin
                pending    <= 1'b1;
                pend_frame <= wframe;
            end else if (consume) pending <= 1'b0;
            // Read data lags the issued channel by one cycle; the last word is folded in during DRAIN.
            if (start) begin
                rframe <= pending ? pend_frame : wframe;
                rch    <= 4'd0;
                acc    <= '0;
            end else if (state == READ) begin
                rch <= rch + 4'd1;
                if (rch != 4'd0) acc <= acc + ext;
            end
            if (state == DRAIN) o_sum <= acc + ext;
        end
    end
endmodule

// File: tb/tb_delay_sum_reader.sv
// tb_delay_sum_reader: directed scenario tests for the delay-and-sum reader.
module tb_delay_sum_reader;
    logic clk = 1'b0;
    logic rst, valid, first;
    logic signed [15:0] sample;
    logic [7:0] delta [15:0];
    logic o_valid, overrun, sync_err;
    logic signed [19:0] o_sum;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last15 = 0;
    int sum_q [$];
    int lat_q [$];
    logic signed [15:0] fv [16];

    delay_sum_reader dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (valid),
        .i_first    (first),
        .i_sample   (sample),
        .i_delta    (delta),
        .o_valid    (o_valid),
        .o_sum      (o_sum),
        .o_overrun  (overrun),
        .o_sync_err (sync_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (o_valid) begin
        sum_q.push_back(int'(o_sum));
        lat_q.push_back(cyc - last15);
    end

    task automatic drive_word(input logic signed [15:0] s, input logic f, input bit last);
        @(negedge clk);
        valid = 1'b1;
        first = f;
        sample = s;
        if (last) last15 = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid = 1'b0;
            first = 1'b0;
        end
    endtask

    task automatic send_frame(input int gap);
        for (int m = 0; m < 16; m++) drive_word(fv[m], m == 0, m == 15);
        idle(gap);
    endtask

    task automatic set_delta(input logic [7:0] d);
        for (int m = 0; m < 16; m++) delta[m] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid = 1'b0;
        first = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_test(input logic [7:0] d, input logic signed [15:0] v);
        do_reset();
        sum_q.delete();
        lat_q.delete();
        set_delta(d);
        for (int m = 0; m < 16; m++) fv[m] = v;
    endtask

    task automatic test_reset();
        start_test(8'd167, 16'sd0);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        checks++; if (o_sum !== 20'sd0) begin errors++; $display("FAIL reset_sum got %0d want 0", o_sum); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err got %b want 0", sync_err); end
    endtask

    task automatic test_warmup();
        int want;
        start_test(8'd167, 16'sd0);
        for (int m = 0; m < 16; m++) fv[m] = 16'(m + 1);
        for (int f = 0; f < 23; f++) begin
            send_frame(24);
            want = f >= 20 ? f - 19 : 0;
            checks++;
            if (sum_q.size() != want) begin
                errors++; $display("FAIL warmup_count frame %0d got %0d outputs want %0d", f, sum_q.size(), want);
            end
            if (f >= 20 && sum_q.size() > 0) begin
                checks++; if (sum_q[$] !== 136) begin errors++; $display("FAIL warmup_sum frame %0d got %0d want 136", f, sum_q[$]); end
                checks++; if (lat_q[$] !== 18) begin errors++; $display("FAIL warmup_latency frame %0d got %0d want 18", f, lat_q[$]); end
            end
        end
    endtask

    task automatic test_max_age();
        start_test(8'd167, 16'sd0);
        delta[0] = 8'd147;
        for (int f = 0; f <= 260; f++) begin
            fv[0] = 16'(f);
            send_frame(4);
        end
        idle(30);
        checks++; if (sum_q.size() != 241) begin errors++; $display("FAIL maxage_count got %0d want 241", sum_q.size()); end
        if (sum_q.size() > 240) begin
            checks++; if (sum_q[10] !== 10) begin errors++; $display("FAIL maxage_frame30 got %0d want 10", sum_q[10]); end
            checks++; if (sum_q[240] !== 240) begin errors++; $display("FAIL maxage_frame260 got %0d want 240", sum_q[240]); end
            for (int i = 0; i < 241; i++) begin
                checks++;
                if (sum_q[i] !== i) begin
                    errors++; $display("FAIL maxage_seq frame %0d got %0d want %0d", i + 20, sum_q[i], i);
                    break;
                end
            end
        end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL maxage_overrun got %b want 0", overrun); end
    endtask

    task automatic test_clamp();
        start_test(8'd167, 16'sd0);
        delta[0] = 8'd200;
        delta[1] = 8'd100;
        for (int f = 0; f < 25; f++) begin
            fv[0] = 16'(f);
            fv[1] = 16'(1000 + f);
            send_frame(4);
        end
        idle(30);
        checks++; if (sum_q.size() != 5) begin errors++; $display("FAIL clamp_count got %0d want 5", sum_q.size()); end
        for (int i = 0; i < 5 && i < sum_q.size(); i++) begin
            checks++;
            if (sum_q[i] !== 2 * (20 + i) + 980) begin
                errors++; $display("FAIL clamp_sum frame %0d got %0d want %0d", 20 + i, sum_q[i], 2 * (20 + i) + 980);
            end
        end
    endtask

    task automatic test_overrun();
        int prev, tag;
        start_test(8'd167, 16'sd0);
        for (int f = 0; f <= 20; f++) begin
            for (int m = 0; m < 16; m++) fv[m] = 16'(f);
            send_frame(4);
        end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_early got %b want 0", overrun); end
        for (int f = 21; f <= 60; f++) begin
            for (int m = 0; m < 16; m++) fv[m] = 16'(f);
            send_frame(0);
        end
        idle(60);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", overrun); end
        checks++;
        if (sum_q.size() <= 20 || sum_q.size() >= 41) begin
            errors++; $display("FAIL overrun_count got %0d want between 21 and 40", sum_q.size());
        end
        prev = 19;
        foreach (sum_q[i]) begin
            tag = sum_q[i] / 16;
            checks++;
            if (sum_q[i] % 16 != 0 || tag <= prev || tag > 60) begin
                errors++; $display("FAIL overrun_sum entry %0d got %0d want 16*frame with frame in %0d..60", i, sum_q[i], prev + 1);
            end
            prev = tag;
        end
    endtask

    task automatic test_resync();
        start_test(8'd167, 16'sd0);
        delta[0] = 8'd166;
        for (int f = 0; f <= 20; f++) begin
            fv[0] = 16'(f);
            send_frame(4);
        end
        idle(20);
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL resync_clean got %b want 0", sync_err); end
        checks++; if (sum_q.size() != 1 || sum_q[$] !== 19) begin errors++; $display("FAIL resync_warm got %0d want 19", sum_q[$]); end
        fv[0] = 16'sd50;
        send_frame(24);
        checks++; if (sum_q[$] !== 20) begin errors++; $display("FAIL resync_pre got %0d want 20", sum_q[$]); end
        for (int m = 0; m < 7; m++) drive_word(m == 0 ? 16'sd1000 : 16'sd0, m == 0, 1'b0);
        fv[0] = 16'sd60;
        send_frame(24);
        checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL resync_flag got %b want 1", sync_err); end
        checks++; if (sum_q[$] !== 50) begin errors++; $display("FAIL resync_frame got %0d want 50", sum_q[$]); end
        checks++; if (lat_q[$] !== 18) begin errors++; $display("FAIL resync_latency got %0d want 18", lat_q[$]); end
        fv[0] = 16'sd70;
        send_frame(24);
        checks++; if (sum_q[$] !== 60) begin errors++; $display("FAIL resync_next got %0d want 60", sum_q[$]); end
        checks++; if (sum_q.size() != 4) begin errors++; $display("FAIL resync_count got %0d want 4", sum_q.size()); end
    endtask

    task automatic test_extremes_and_reset();
        start_test(8'd167, 16'sh8000);
        for (int f = 0; f <= 20; f++) send_frame(4);
        idle(20);
        checks++; if (sum_q.size() != 1) begin errors++; $display("FAIL extreme_count got %0d want 1", sum_q.size()); end
        checks++; if (sum_q[0] !== -524288) begin errors++; $display("FAIL extreme_sum got %0d want -524288", sum_q[0]); end
        send_frame(5);
        do_reset();
        idle(30);
        checks++; if (sum_q.size() != 1) begin errors++; $display("FAIL midreset_valid got %0d outputs want 1", sum_q.size()); end
        checks++; if (o_sum !== 20'sd0) begin errors++; $display("FAIL midreset_sum got %0d want 0", o_sum); end
        for (int m = 0; m < 16; m++) fv[m] = 16'sd5;
        for (int f = 0; f < 20; f++) send_frame(4);
        idle(30);
        checks++; if (sum_q.size() != 1) begin errors++; $display("FAIL midreset_silent got %0d outputs want 1", sum_q.size()); end
        send_frame(30);
        checks++; if (sum_q.size() != 2) begin errors++; $display("FAIL midreset_resume got %0d outputs want 2", sum_q.size()); end
        checks++; if (sum_q[$] !== 80) begin errors++; $display("FAIL midreset_sum80 got %0d want 80", sum_q[$]); end
    endtask

    initial begin
        rst = 1'b1;
        valid = 1'b0;
        first = 1'b0;
        sample = 16'sd0;
        set_delta(8'd167);
        repeat (3) @(negedge clk);
        test_reset();
        test_warmup();
        test_max_age();
        test_clamp();
        test_overrun();
        test_resync();
        test_extremes_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
